// File: rtl/uart_pkg.sv
// Shared types and defaults for the 8-bit parity UART receive path.
// Holds the receiver state enum, parity-type encodings and frame defaults.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_t;

   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   localparam int DEFAULT_CLKS_PER_BIT = 27;
   localparam int FRAME_BITS           = 11;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
// Ports: clk, rst_n (async active-low), d (async in), q (synchronised out).
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_checked.sv
// UART receiver: start, 8 data bits LSB-first, parity, stop; with error flags.
// Ports: clk_3125, rst_n, parity_type, rx in; rx_msg, rx_parity, rx_complete,
//        parity_err, frame_err, busy out.
module uart_rx_checked
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk_3125,
   input  logic       rst_n,
   input  logic       parity_type,
   input  logic       rx,
   output logic [7:0] rx_msg,
   output logic       rx_parity,
   output logic       rx_complete,
   output logic       parity_err,
   output logic       frame_err,
   output logic       busy
);

   if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("CLKS_PER_BIT must be at least 4");
   end

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   logic rx_s;

   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk  (clk_3125),
      .rst_n(rst_n),
      .d    (rx),
      .q    (rx_s)
   );

   rx_state_t     state, state_nx;
   logic [CW-1:0] clk_cnt, clk_cnt_nx;
   logic [2:0]    bit_cnt, bit_cnt_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          par_bit, par_bit_nx;
   logic          ptype, ptype_nx;
   logic [7:0]    msg_nx;
   logic          rxpar_nx, perr_nx, ferr_nx;
   logic          done_nx, busy_nx;
   logic          bit_end;

   always_ff @(posedge clk_3125 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         clk_cnt     <= '0;
         bit_cnt     <= '0;
         shreg       <= '0;
         par_bit     <= 1'b0;
         ptype       <= 1'b0;
         rx_msg      <= '0;
         rx_parity   <= 1'b0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         rx_complete <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nx;
         clk_cnt     <= clk_cnt_nx;
         bit_cnt     <= bit_cnt_nx;
         shreg       <= shreg_nx;
         par_bit     <= par_bit_nx;
         ptype       <= ptype_nx;
         rx_msg      <= msg_nx;
         rx_parity   <= rxpar_nx;
         parity_err  <= perr_nx;
         frame_err   <= ferr_nx;
         rx_complete <= done_nx;
         busy        <= busy_nx;
      end
   end

   assign bit_end = (clk_cnt == BIT_LAST);

   always_comb begin
      state_nx   = state;
      clk_cnt_nx = clk_cnt;
      bit_cnt_nx = bit_cnt;
      shreg_nx   = shreg;
      par_bit_nx = par_bit;
      ptype_nx   = ptype;
      msg_nx     = rx_msg;
      rxpar_nx   = rx_parity;
      perr_nx    = parity_err;
      ferr_nx    = frame_err;
      done_nx    = 1'b0;
      busy_nx    = busy;

      unique case (state)
         IDLE: begin
            clk_cnt_nx = '0;
            bit_cnt_nx = '0;
            if (!rx_s) state_nx = START;
         end
         START: begin
            if (clk_cnt == HALF_LAST) begin
               clk_cnt_nx = '0;
               // Line back high at mid-start: a glitch, drop it quietly.
               if (!rx_s) begin
                  ptype_nx = parity_type;
                  busy_nx  = 1'b1;
                  state_nx = DATA;
               end else begin
                  state_nx = IDLE;
               end
            end else begin
               clk_cnt_nx = clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_end) begin
               clk_cnt_nx = '0;
               shreg_nx   = {rx_s, shreg[7:1]};
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_nx = PARITY;
            end else begin
               clk_cnt_nx = clk_cnt + 1'b1;
            end
         end
         PARITY: begin
            if (bit_end) begin
               clk_cnt_nx = '0;
               par_bit_nx = rx_s;
               state_nx   = STOP;
            end else begin
               clk_cnt_nx = clk_cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               clk_cnt_nx = '0;
               msg_nx     = shreg;
               rxpar_nx   = par_bit;
               perr_nx    = ((^shreg) ^ par_bit) != ptype;
               ferr_nx    = ~rx_s;
               done_nx    = 1'b1;
               // A low stop means a break; wait for idle before rearming.
               if (rx_s) begin
                  busy_nx  = 1'b0;
                  state_nx = IDLE;
               end else begin
                  state_nx = BREAK;
               end
            end else begin
               clk_cnt_nx = clk_cnt + 1'b1;
            end
         end
         BREAK: begin
            if (rx_s) begin
               busy_nx  = 1'b0;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: doc/uart_rx_checked.md
Name: uart_rx_checked

Overview:
- Standalone UART receiver. It deserialises 11-bit frames into bytes: start, 8 data bits LSB-first, parity, stop.
- It is the receive end of the team's 8-bit parity UART link. It sits on the clk_3125 (3.125 MHz) domain and listens to the tx line of a uart_rxtx transmitter.
- It adds input synchronisation, start-glitch rejection and parity/framing error flags.

Parameters:
- CLKS_PER_BIT, 27, clk_3125 cycles per bit (≈115200 baud); must be ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2 (13), cycles from synchronised start edge to the start-bit mid-sample.

Ports:
- clk_3125  in  1  system clock, 3.125 MHz
- rst_n  in  1  reset, asynchronous assert, active-low
- parity_type  in  1  0 = even, 1 = odd; sampled when a frame's start bit is confirmed
- rx  in  1  serial line, idle high, asynchronous to clk_3125
- rx_msg  out  8  last received byte
- rx_parity  out  1  parity bit as received on the line
- rx_complete  out  1  one-cycle pulse when a frame finishes
- parity_err  out  1  received parity mismatches the computed parity; valid with rx_complete
- frame_err  out  1  stop bit sampled 0; valid with rx_complete
- busy  out  1  high from confirmed start until return to IDLE

Behaviour:
- Reset (async, rst_n=0):
  - rx_msg = 0x00; rx_parity, rx_complete, parity_err, frame_err, busy = 0.
  - Synchroniser flops = 1; state = IDLE; counters = 0.
  - Reset mid-frame aborts the frame silently: no rx_complete, outputs cleared.
- Synchronisation: rx passes through 2 flops (rx_s). All logic uses rx_s, which adds 2 cycles of latency.
- State machine; bit_cnt 0..7 and clk_cnt 0..CLKS_PER_BIT-1 are used throughout.
  - IDLE: wait for rx_s=0; then clk_cnt=0 and go to START.
  - START:
    - At clk_cnt=HALF_BIT-1, sample rx_s.
    - If 0: latch parity_type, set busy, go to DATA with clk_cnt=0.
    - If 1 (glitch): return to IDLE, no outputs change.
  - DATA:
    - Sample every CLKS_PER_BIT cycles, at clk_cnt=CLKS_PER_BIT-1.
    - Shift in LSB-first into the internal shift register. After bit_cnt=7, go to PARITY.
  - PARITY: sample the parity bit after one bit period; go to STOP.
  - STOP: sample the stop bit after one bit period, then in the next cycle:
    - rx_msg ← shift register; rx_parity ← sampled parity bit.
    - parity_err ← (^data ^ rx_parity) != latched parity_type.
    - frame_err ← ~stop_sample; pulse rx_complete for one cycle.
    - If stop=1: go to IDLE and clear busy. The next start may be accepted from the following cycle.
    - If stop=0: go to BREAK.
  - BREAK: wait for rx_s=1, then IDLE and clear busy. A held-low line is never treated as a new start.
- Timing relative to the first cycle rx_s=0:
  - Start mid-sample at +13.
  - Data bit k (k=0..7) sampled at +13+27(k+1).
  - Parity sampled at +256; stop sampled at +283.
  - rx_complete high at +284.
- Output stability:
  - rx_msg, rx_parity, parity_err and frame_err change only in the rx_complete cycle and hold until the next completed frame.
  - An errored frame still updates rx_msg.
- parity_type changes mid-frame have no effect on the current frame.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - PARITY_EVEN=0, PARITY_ODD=1;
  - default CLKS_PER_BIT=27 and FRAME_BITS=11.
- One sub-module is natural: sync_2ff, a generic 2-flop synchroniser with async active-low reset and a reset value parameter (here 1).

Test Plan:
- 'P' 0x50, even: frame 0,00001010,0,1 at 27 clks/bit → rx_complete at +284, rx_msg=0x50, rx_parity=0, parity_err=0, frame_err=0.
- 'a' 0x61, odd: parity bit 0 sent → rx_msg=0x61, rx_parity=0, parity_err=0. Repeat with parity bit 1 → parity_err=1, rx_msg still 0x61.
- Framing: 0x72 with stop=0 held low for 100 clks → rx_complete with frame_err=1. No further rx_complete until rx returns high, then a new frame is received normally.
- Glitch: rx low for 5 clks then high → no busy, no rx_complete, outputs unchanged.
- Back-to-back "PartH" (0x50,0x61,0x72,0x74,0x48), even parity, no idle gap → five rx_complete pulses 297 clks apart, bytes in order, all error flags 0.
- Reset mid-frame: rst_n low during data bit 4 of 0x74 → all outputs 0 immediately, no rx_complete. The next full frame 0x48 is received correctly.
